program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 27 ++
 rtl/program_loader_if.sv | 34 +++
 rtl/byte_assembler.sv | 30 +++
 rtl/program_loader.sv | 129 ++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants and FSM encoding for the host program loader.
// Imported by the loader top and its byte assembler.
package loader_pkg;

  localparam logic [7:0] OP_I = 8'h49;
  localparam logic [7:0] OP_D = 8'h44;
  localparam logic [7:0] OP_G = 8'h47;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_BYTES     = 4;
  localparam int LEN_BYTES      = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_GO
  } state_t;

  function automatic logic is_load_op(
    input logic [7:0] b
  );
    return (b == OP_I) || (b == OP_D);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream in, cache write ports and control out.
// master = host/processor side, slave = loader side.
interface program_loader_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] IData_out;
  logic [31:0] IAddr_out;
  logic        icache_we;
  logic [31:0] DData_out;
  logic [31:0] DAddr_out;
  logic        dcache_we;
  logic        start;
  logic        busy;
  logic        err;

  modport master (
    output in_valid, in_data,
    input  in_ready,
    input  IData_out, IAddr_out, icache_we,
    input  DData_out, DAddr_out, dcache_we,
    input  start, busy, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready,
    output IData_out, IAddr_out, icache_we,
    output DData_out, DAddr_out, dcache_we,
    output start, busy, err
  );

endinterface

// File: rtl/byte_assembler.sv
// MSB-first byte-to-word assembly with a 2-bit byte index.
// word/last present the completed word combinationally on byte 3.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last
);

  logic [23:0] sh;
  logic [1:0]  idx;

  assign word = {sh, din};
  assign last = (idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      idx <= '0;
    end else if (en) begin
      sh  <= word[23:0];
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Parses I/D/G packets from a host byte stream and
// writes assembled words into the instruction/data caches.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_STEP = 1,
  parameter int unsigned MAX_WORDS = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  program_loader_if.slave   bus
);

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] addr_r;
  logic [15:0] len_r;
  logic [15:0] left;
  logic        sel_d;
  logic        acc;
  logic [15:0] len_full;
  logic [31:0] asm_word;
  logic        asm_last;

  assign bus.in_ready = ~rst & (state != S_GO);
  assign bus.busy     = (state != S_IDLE);
  assign acc          = bus.in_valid & bus.in_ready;
  assign len_full     = {len_r[7:0], bus.in_data};

  byte_assembler u_asm (
    .clk  (clk),
    .rst  (rst),
    .en   (acc && (state == S_DATA)),
    .din  (bus.in_data),
    .word (asm_word),
    .last (asm_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      addr_r        <= '0;
      len_r         <= '0;
      left          <= '0;
      sel_d         <= 1'b0;
      bus.IData_out <= '0;
      bus.IAddr_out <= '0;
      bus.icache_we <= 1'b0;
      bus.DData_out <= '0;
      bus.DAddr_out <= '0;
      bus.dcache_we <= 1'b0;
      bus.start     <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.icache_we <= 1'b0;
      bus.dcache_we <= 1'b0;
      bus.start     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (acc) begin
            unique case (1'b1)
              is_load_op(bus.in_data): begin
                sel_d   <= (bus.in_data == OP_D);
                bus.err <= 1'b0;
                cnt     <= '0;
                state   <= S_ADDR;
              end
              (bus.in_data == OP_G): begin
                bus.err   <= 1'b0;
                bus.start <= 1'b1;
                state     <= S_GO;
              end
              default: bus.err <= 1'b1;
            endcase
          end
        end
        S_ADDR: begin
          if (acc) begin
            addr_r <= {addr_r[23:0], bus.in_data};
            cnt    <= cnt + 2'd1;
            if (cnt == 2'(ADDR_BYTES - 1)) begin
              cnt   <= '0;
              state <= S_LEN;
            end
          end
        end
        S_LEN: begin
          if (acc) begin
            len_r <= len_full;
            cnt   <= cnt + 2'd1;
            if (cnt == 2'(LEN_BYTES - 1)) begin
              cnt  <= '0;
              left <= len_full;
              // oversize counts are rejected before any data byte
              if (len_full == '0) begin
                state <= S_IDLE;
              end else if (32'(len_full) > MAX_WORDS) begin
                bus.err <= 1'b1;
                state   <= S_IDLE;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (acc && asm_last) begin
            if (sel_d) begin
              bus.DData_out <= asm_word;
              bus.DAddr_out <= addr_r;
              bus.dcache_we <= 1'b1;
            end else begin
              bus.IData_out <= asm_word;
              bus.IAddr_out <= addr_r;
              bus.icache_we <= 1'b1;
            end
            addr_r <= addr_r + 32'(ADDR_STEP);
            left   <= left - 16'd1;
            if (left == 16'd1) state <= S_IDLE;
          end
        end
        S_GO:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
